// File: rtl/rom_if_pkg.sv
// Shared definitions for the 16x8 ROM read interface and its initiators.
package rom_if_pkg;

  localparam int unsigned ROM_ADDR_W = 4;
  localparam int unsigned ROM_DATA_W = 8;
  localparam int unsigned ROM_DEPTH  = 2 ** ROM_ADDR_W;

  // Scan reader control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    OUT  = 2'd2,
    DONE = 2'd3
  } scan_state_t;

endpackage : rom_if_pkg

// File: rtl/rom_scan_reader.sv
// ROM scan reader: walks a wrapping address range and reads each byte after a
// programmable latency. Each byte is streamed out on valid/ready and added to a
// mod-2**DATA_W checksum.
module rom_scan_reader
  import rom_if_pkg::*;
#(
  parameter int unsigned ADDR_W   = ROM_ADDR_W,
  parameter int unsigned DATA_W   = ROM_DATA_W,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   count,
  output logic              cs,
  output logic              read_en,
  output logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] datab,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  scan_state_t      state;
  logic [CNT_W-1:0] remaining;
  logic [LAT_W-1:0] lat_cnt;

  // Scan FSM; addrb doubles as the internal scan address register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cs        <= 1'b0;
      read_en   <= 1'b0;
      addrb     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      checksum  <= '0;
      remaining <= '0;
      lat_cnt   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            checksum  <= '0;
            busy      <= 1'b1;
            addrb     <= start_addr;
            remaining <= count;
            lat_cnt   <= '0;
            if (count != '0) begin
              state   <= READ;
              cs      <= 1'b1;
              read_en <= 1'b1;
            end else begin
              // Empty scan: straight to the done pulse, no ROM access
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end

        READ: begin
          if (lat_cnt == LAT_W'(READ_LAT - 1)) begin
            out_data  <= datab;
            out_valid <= 1'b1;
            cs        <= 1'b0;
            read_en   <= 1'b0;
            state     <= OUT;
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end

        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            checksum  <= checksum + out_data;
            remaining <= remaining - CNT_W'(1);
            addrb     <= addrb + ADDR_W'(1);
            lat_cnt   <= '0;
            if (remaining == CNT_W'(1)) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state   <= READ;
              cs      <= 1'b1;
              read_en <= 1'b1;
            end
          end
        end

        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : rom_scan_reader

// File: tb/tb_rom_scan_reader.sv
// Scoreboard bench for rom_scan_reader against a behavioural 16x8 ROM.
module tb_rom_scan_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, out_ready;
  logic [3:0] start_addr, addrb;
  logic [4:0] count;
  logic       cs, read_en, out_valid, busy, done;
  logic [7:0] datab, out_data, checksum;

  // Second build with READ_LAT=3
  logic       start_b;
  logic [3:0] start_addr_b, addrb_b;
  logic [4:0] count_b;
  logic       cs_b, read_en_b, out_valid_b, busy_b, done_b;
  logic [7:0] datab_b, out_data_b, checksum_b;

  logic [7:0] rom [16];

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  logic [7:0] exp_q[$];
  logic [3:0] exp_addr_q[$];
  logic cs_prev = 1'b0;

  always #5 clk = ~clk;

  // Behavioural ROM responders
  assign datab   = (cs && read_en) ? rom[addrb] : 8'h00;
  assign datab_b = (cs_b && read_en_b) ? rom[addrb_b] : 8'h00;

  rom_scan_reader #(.ADDR_W(4), .DATA_W(8), .READ_LAT(1)) dut (
    .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .count(count),
    .cs(cs), .read_en(read_en), .addrb(addrb), .datab(datab),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .checksum(checksum)
  );

  rom_scan_reader #(.ADDR_W(4), .DATA_W(8), .READ_LAT(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .start_addr(start_addr_b), .count(count_b),
    .cs(cs_b), .read_en(read_en_b), .addrb(addrb_b), .datab(datab_b),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(1'b1),
    .busy(busy_b), .done(done_b), .checksum(checksum_b)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: handshakes, access addresses and ROM strobe sanity, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", 1, 0);
        else check("byte", int'(out_data), int'(exp_q.pop_front()));
      end
      if (cs && !cs_prev) begin
        if (exp_addr_q.size() == 0) check("unexpected_access", 1, 0);
        else check("addrb", int'(addrb), int'(exp_addr_q.pop_front()));
      end
      if (cs && (!read_en || out_valid)) check("strobe_excl", 1, 0);
      if (done) done_cnt++;
    end
    cs_prev <= cs;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue a scan, push expectations, optionally pulse a stray start at cycle pulse_at
  task automatic scan(input int sa, input int cnt, input int pulse_at, output int n);
    for (int i = 0; i < cnt; i++) begin
      exp_q.push_back(rom[(sa + i) % 16]);
      exp_addr_q.push_back(4'((sa + i) % 16));
    end
    start_addr = 4'(sa);
    count      = 5'(cnt);
    start      = 1'b1;
    step();
    start = 1'b0;
    n = 1;
    while (!done && n < 200) begin
      if (n == pulse_at) begin
        start_addr = 4'd9;
        count      = 5'd1;
        start      = 1'b1;
      end
      step();
      start = 1'b0;
      n++;
    end
    if (n >= 200) check("done_timeout", 0, 1);
  endtask

  initial begin
    int n, d0, csn;
    rom = '{8'd21, 8'd255, 8'd33, 8'd99, 8'd127, 8'd13, 8'd10, 8'd88,
            8'd28, 8'd38, 8'd48, 8'd58, 8'd68, 8'd78, 8'd88, 8'd98};
    rst = 1'b1; start = 1'b0; out_ready = 1'b1; start_addr = '0; count = '0;
    start_b = 1'b0; start_addr_b = '0; count_b = '0;
    step(); step();
    check("rst_outputs", int'({cs, read_en, addrb, out_valid, busy, done, out_data, checksum}), 0);
    rst = 1'b0;
    step();

    // Full scan, ready tied high
    d0 = done_cnt;
    scan(0, 16, -1, n);
    check("full_cycles", n, 33);
    check("full_busy", int'(busy), 1);
    check("full_checksum", int'(checksum), 126);
    step();
    check("full_done_once", done_cnt - d0, 1);
    check("full_idle", int'({busy, done}), 0);
    check("full_q_empty", exp_q.size(), 0);

    // Wrap from 14
    scan(14, 4, -1, n);
    check("wrap_cycles", n, 9);
    check("wrap_checksum", int'(checksum), 206);
    check("wrap_addr_q_empty", exp_addr_q.size(), 0);
    step();

    // Backpressure for 3 cycles on the first byte
    out_ready = 1'b0;
    exp_q.push_back(8'd21); exp_q.push_back(8'd255);
    exp_addr_q.push_back(4'd0); exp_addr_q.push_back(4'd1);
    start_addr = 4'd0; count = 5'd2; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin step(); n++; end
    check("bp_valid_latency", n, 1);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_data", int'(out_data), 21);
      check("bp_hold_strobes", int'({cs, read_en, out_valid}), 1);
      step();
    end
    out_ready = 1'b1;
    n = 0;
    while (!done && n < 20) begin step(); n++; end
    check("bp_checksum", int'(checksum), 20);
    check("bp_q_empty", exp_q.size(), 0);
    step();

    // Empty scan
    start_addr = 4'd3; count = 5'd0; start = 1'b1;
    step();
    start = 1'b0;
    check("zero_done_busy", int'({done, busy, cs, read_en}), 4'b1100);
    check("zero_checksum", int'(checksum), 0);
    step();
    check("zero_after", int'({done, busy, cs}), 0);

    // Stray start mid-scan is ignored
    scan(3, 8, 5, n);
    check("ign_cycles", n, 17);
    check("ign_checksum", int'(checksum), 195);
    check("ign_q_empty", exp_q.size() + exp_addr_q.size(), 0);
    step();

    // Reset after the second handshake
    d0 = done_cnt;
    exp_q.push_back(8'd13); exp_q.push_back(8'd10);
    exp_addr_q.push_back(4'd5); exp_addr_q.push_back(4'd6);
    start_addr = 4'd5; count = 5'd6; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    #1;
    check("abort_outputs", int'({cs, read_en, addrb, out_valid, busy, done, out_data, checksum}), 0);
    check("abort_q_empty", exp_q.size(), 0);
    step(); step();
    rst = 1'b0;
    step();
    check("abort_no_done", done_cnt - d0, 0);
    exp_addr_q.delete();
    scan(12, 2, -1, n);
    check("restart_cycles", n, 5);
    check("restart_checksum", int'(checksum), 146);
    step();

    // READ_LAT=3 build, single byte at 8
    start_addr_b = 4'd8; count_b = 5'd1; start_b = 1'b1;
    step();
    start_b = 1'b0;
    n = 1; csn = 0;
    while (!done_b && n < 40) begin
      if (cs_b) begin
        csn++;
        check("lat3_addr", int'(addrb_b), 8);
        check("lat3_read_en", int'(read_en_b), 1);
      end
      if (out_valid_b) check("lat3_data", int'(out_data_b), 28);
      step();
      n++;
    end
    check("lat3_cs_cycles", csn, 3);
    check("lat3_cycles", n, 5);
    check("lat3_checksum", int'(checksum_b), 28);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_rom_scan_reader

// File: doc/rom_scan_reader.md
Name: rom_scan_reader

Overview:
Initiator side of the team's 16x8 ROM read interface (cs, addrb, read_en, datab).
- On a start command, walks a contiguous, wrapping address range and drives cs/read_en/addrb.
- Captures each byte after a programmable read latency.
- Streams captured bytes out on a valid/ready handshake and accumulates a mod-256 checksum.
- Sits between the ROM macro and any byte consumer (display, UART tx, comparator).

Parameters:
- ADDR_W, 4, ROM address width; depth = 2**ADDR_W.
- DATA_W, 8, ROM data width.
- READ_LAT, 1, cycles cs/read_en are held per access before datab is sampled (>=1).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle command strobe; accepted only in IDLE
- start_addr  in  ADDR_W  first address of scan
- count  in  ADDR_W+1  number of bytes to read, 0..16
- cs  out  1  ROM chip select
- read_en  out  1  ROM read enable
- addrb  out  ADDR_W  ROM address
- datab  in  DATA_W  ROM data; may be Z when cs/read_en low
- out_data  out  DATA_W  captured byte
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data
- busy  out  1  high from the cycle after start is accepted through DONE
- done  out  1  one-cycle pulse at end of scan
- checksum  out  DATA_W  sum mod 2**DATA_W of bytes handed off in the current/last scan

Behaviour:
- Reset (async, any state): state=IDLE. cs, read_en, addrb, out_data, out_valid, busy, done and checksum all =0. Internal address, remaining count and latency counter =0.
- IDLE, start=1, count>0:
  - Latch addr=start_addr, remaining=count.
  - Clear checksum.
  - Next state READ.
- IDLE, start=1, count=0: next state DONE, with checksum cleared to 0 and no ROM access.
- READ:
  - cs=read_en=1, addrb=addr; latency counter runs from 0 to READ_LAT-1.
  - At the end of the last READ cycle, register datab into out_data; next state OUT.
  - cs/read_en are high only in READ; datab is never sampled elsewhere.
- OUT:
  - out_valid=1, out_data stable, cs=read_en=0.
  - Hold until out_valid&&out_ready (handshake cycle).
  - On handshake: checksum += out_data (mod 256), remaining--, addr = addr+1 mod 2**ADDR_W (15 wraps to 0).
  - Then go to DONE if remaining reaches 0, else READ.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. checksum holds until the next accepted start.
- Timing: start accepted at edge T; first READ cycle is T+1; out_valid first high at cycle T+1+READ_LAT. With out_ready tied high, each byte costs READ_LAT+1 cycles.
- start while busy or in DONE: ignored, no effect.
- out_ready high outside OUT: ignored.
- Reset mid-scan: aborts immediately. No done pulse; the partial checksum is lost (0).

Decomposition:
- Shared package rom_if_pkg:
  - ROM_ADDR_W=4, ROM_DATA_W=8, ROM_DEPTH=16.
  - State enum {IDLE, READ, OUT, DONE}.
- No sub-module; FSM, counters and checksum stay flat.
- The bench instantiates the existing 16x8 ROM as the responder.

Test Plan:
- Full scan: start_addr=0, count=16, out_ready=1, READ_LAT=1 -> bytes 21,255,33,99,127,13,10,88,28,38,48,58,68,78,88,98 in order; out_valid every 2nd cycle; done once; checksum=126.
- Wrap: start_addr=14, count=4 -> bytes 88,98,21,255; addrb sequence 14,15,0,1; checksum=206.
- Backpressure: start_addr=0, count=2, out_ready low 3 cycles after first out_valid -> out_data held at 21, cs=read_en=0 during hold; then 255; checksum=20.
- count=0: start -> no cs/read_en assertion; done pulses the cycle after start; checksum=0; busy high that one cycle.
- Ignored start / reset abort:
  - start pulsed during a count=8 scan -> scan unaffected.
  - rst asserted after the 2nd handshake -> all outputs 0 in the same cycle.
  - A new start after rst deasserts scans correctly from the new start_addr.
- READ_LAT=3 build: start_addr=8, count=1 -> cs/read_en high exactly 3 cycles at addrb=8; out_data=28; checksum=28.
